// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle WIDTH-bit subtractor computing DIFF = X - Y - BIN,
// DIGIT_W bits per clock, LSB digit first, with the borrow carried in a register
// between digits. A START/BUSY/DONE handshake frames each operation and the
// result is published (with borrow-out, signed overflow and zero flags) only
// once the final digit is done, so partial digits never appear on diff.
module serial_subtractor #(
  parameter int WIDTH   = 16,
  parameter int DIGIT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf,
  output logic             zero
);

  // Number of digit cycles per operation; guarded so a bad DIGIT_W still elaborates
  // far enough to reach the parameter check below.
  localparam int N     = (DIGIT_W > 0) ? (WIDTH / DIGIT_W) : 1;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  // Reject parameter combinations that cannot be split into whole digits.
  generate
    if (WIDTH < 1 || DIGIT_W < 1 || (WIDTH % DIGIT_W) != 0) begin : g_bad_param
      $error("serial_subtractor: DIGIT_W (%0d) must be >= 1 and divide WIDTH (%0d)",
             DIGIT_W, WIDTH);
    end
  endgenerate

  // FIN is the single cycle in which DONE is shown; a START there chains straight
  // into the next operation without passing through IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Operand shift registers: the active digit is always in the low DIGIT_W bits.
  logic [WIDTH-1:0] x_sh_reg;
  logic [WIDTH-1:0] y_sh_reg;
  // Sign bits of the accepted operands, kept because the shifters lose them.
  logic             x_msb_reg;
  logic             y_msb_reg;
  logic             borrow_reg;
  logic [CNT_W-1:0] cnt_reg;
  // Partial result: new digits enter at the top and move down, so after N digits
  // digit 0 sits at the bottom.
  logic [WIDTH-1:0] res_reg;

  // Published result registers; they change only on the last digit edge or reset.
  logic [WIDTH-1:0] diff_reg;
  logic             b_out_reg;
  logic             ovf_reg;
  logic             zero_reg;

  logic                     accept;
  logic                     last_digit;
  logic [DIGIT_W-1:0]       x_dig;
  logic [DIGIT_W-1:0]       y_dig;
  logic [DIGIT_W-1:0]       d_dig;
  logic [DIGIT_W:0]         bchain;
  logic [WIDTH+DIGIT_W-1:0] res_wide;
  logic [WIDTH-1:0]         res_next;

  // START is honoured in IDLE and in FIN (back-to-back), never while digits run.
  assign accept     = start && (state_reg != S_RUN);
  assign last_digit = (state_reg == S_RUN) && (cnt_reg == CNT_W'(N - 1));

  assign x_dig = x_sh_reg[DIGIT_W-1:0];
  assign y_dig = y_sh_reg[DIGIT_W-1:0];

  // One digit is a ripple of 1-bit full subtractors; the incoming borrow is the
  // registered borrow from the previous (less significant) digit.
  assign bchain[0] = borrow_reg;
  generate
    for (genvar gi = 0; gi < DIGIT_W; gi++) begin : g_fs
      assign d_dig[gi]    = x_dig[gi] ^ y_dig[gi] ^ bchain[gi];
      assign bchain[gi+1] = (~x_dig[gi] & y_dig[gi]) |
                            (~(x_dig[gi] ^ y_dig[gi]) & bchain[gi]);
    end
  endgenerate

  // Concatenate-then-slice works for every legal DIGIT_W, including DIGIT_W == WIDTH.
  assign res_wide = {d_dig, res_reg};
  assign res_next = res_wide[WIDTH+DIGIT_W-1:DIGIT_W];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> FIN after the last digit,
  // FIN -> RUN on start else IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (last_digit) begin
          state_next = S_FIN;
        end
      end
      S_FIN: begin
        if (start) begin
          state_next = S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from the state alone, so they are glitch-free.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      S_RUN:   busy = 1'b1;
      S_FIN:   done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Operand capture on accept, then one digit consumed per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_sh_reg   <= '0;
      y_sh_reg   <= '0;
      x_msb_reg  <= 1'b0;
      y_msb_reg  <= 1'b0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
      res_reg    <= '0;
    end else if (accept) begin
      x_sh_reg   <= x;
      y_sh_reg   <= y;
      x_msb_reg  <= x[WIDTH-1];
      y_msb_reg  <= y[WIDTH-1];
      borrow_reg <= bin;
      cnt_reg    <= '0;
      res_reg    <= '0;
    end else if (state_reg == S_RUN) begin
      x_sh_reg   <= x_sh_reg >> DIGIT_W;
      y_sh_reg   <= y_sh_reg >> DIGIT_W;
      borrow_reg <= bchain[DIGIT_W];
      cnt_reg    <= cnt_reg + CNT_W'(1);
      res_reg    <= res_next;
    end
  end

  // Publish difference and flags together on the final digit edge; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_reg  <= '0;
      b_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      zero_reg  <= 1'b0;
    end else if (last_digit) begin
      diff_reg  <= res_next;
      b_out_reg <= bchain[DIGIT_W];
      // Signed overflow: operands of opposite sign and the result sign differs
      // from the minuend sign.
      ovf_reg   <= (x_msb_reg != y_msb_reg) && (res_next[WIDTH-1] != x_msb_reg);
      zero_reg  <= (res_next == '0);
    end
  end

  assign diff  = diff_reg;
  assign b_out = b_out_reg;
  assign ovf   = ovf_reg;
  assign zero  = zero_reg;

endmodule
